wb_port_arbiter: RTL

Arbitrates the single register-file write port between two writeback requesters: the single-cycle ALU path (req0) and a multi-cycle unit such as load or multiply (req1). Winning requests land in a one-entry commit stage that drives the register unit's write-enable, address and data. The block also exposes forwarding lookups so read ports can see a staged, not-yet-committed write. It sits between the execute/memory stages and the register unit.

---
 rtl/wb_pkg.sv | 12 +
 rtl/wb_rr_pick.sv | 27 ++
 rtl/wb_port_arbiter.sv | 102 ++++++++++
 3 files changed

// File: rtl/wb_pkg.sv
// Shared writeback definitions: data/address widths and the request payload.
package wb_pkg;

    localparam int XLEN = 32;
    localparam int AW   = 5;

    typedef struct packed {
        logic [AW-1:0]   rd;
        logic [XLEN-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/wb_rr_pick.sv
// Two-way writeback grant selection.
// Build option: WB_ARB_RR_EN selects round-robin on contention
// (pointer input present); otherwise requester 0 always wins.
module wb_rr_pick (
    input  logic       i_v0,
    input  logic       i_v1,
`ifdef WB_ARB_RR_EN
    input  logic       i_ptr,
`endif
    output logic [1:0] o_gnt
);

    // One-hot grant: single requester wins outright, contention uses the policy
    always_comb begin
        o_gnt = 2'b00;
        if (i_v0 && i_v1) begin
`ifdef WB_ARB_RR_EN
            o_gnt = i_ptr ? 2'b10 : 2'b01;
`else
            o_gnt = 2'b01;
`endif
        end else begin
            o_gnt = {i_v1, i_v0};
        end
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: two writeback requesters feed a
// one-entry commit stage that drives the register unit, with forwarding
// lookups against the staged write.
// Build option: WB_ARB_RR_EN enables round-robin arbitration; without it
// req0 has fixed priority and no pointer flop exists.
module wb_port_arbiter
    import wb_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req0_valid,
    input  logic [AW-1:0]   req0_rd,
    input  logic [XLEN-1:0] req0_data,
    output logic            req0_ready,
    input  logic            req1_valid,
    input  logic [AW-1:0]   req1_rd,
    input  logic [XLEN-1:0] req1_data,
    output logic            req1_ready,
    input  logic            wr_hold,
    output logic            RUWr,
    output logic [AW-1:0]   rd,
    output logic [XLEN-1:0] data_in,
    input  logic [AW-1:0]   rs1,
    input  logic [AW-1:0]   rs2,
    output logic            fwd1_hit,
    output logic            fwd2_hit,
    output logic [XLEN-1:0] fwd1_data,
    output logic [XLEN-1:0] fwd2_data
);

    logic       r_stg_valid;
    wb_req_t    r_stg;
    logic [1:0] w_gnt;
    logic       w_accept_ok;
    logic       w_xfer;
    logic       w_drain;
    wb_req_t    w_win;
    logic       w_fwd1_hit;
    logic       w_fwd2_hit;

`ifdef WB_ARB_RR_EN
    logic       r_ptr;
`endif

    wb_rr_pick u_pick (
        .i_v0  (req0_valid),
        .i_v1  (req1_valid),
`ifdef WB_ARB_RR_EN
        .i_ptr (r_ptr),
`endif
        .o_gnt (w_gnt)
    );

    // Handshake, drain and winner selection
    always_comb begin
        w_accept_ok = !r_stg_valid || !wr_hold;
        w_drain     = r_stg_valid && !wr_hold;
        w_xfer      = (|w_gnt) && w_accept_ok;
        req0_ready  = w_gnt[0] && w_accept_ok;
        req1_ready  = w_gnt[1] && w_accept_ok;
        w_win.rd    = w_gnt[1] ? req1_rd   : req0_rd;
        w_win.data  = w_gnt[1] ? req1_data : req0_data;
    end

    // Commit stage: a new winner loads on the same edge the old entry drains
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stg_valid <= 1'b0;
            r_stg       <= '0;
        end else if (w_xfer) begin
            r_stg_valid <= 1'b1;
            r_stg       <= w_win;
        end else if (w_drain) begin
            r_stg_valid <= 1'b0;
        end
    end

`ifdef WB_ARB_RR_EN
    // Round-robin pointer: after a contended grant, prefer the loser next
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= 1'b0;
        end else if (w_xfer && req0_valid && req1_valid) begin
            r_ptr <= w_gnt[0];
        end
    end
`endif

    // Register-file write port and forwarding lookups (forwarding ignores wr_hold)
    always_comb begin
        RUWr       = r_stg_valid && !wr_hold && (r_stg.rd != '0);
        rd         = r_stg.rd;
        data_in    = r_stg.data;
        w_fwd1_hit = r_stg_valid && (r_stg.rd != '0) && (rs1 == r_stg.rd);
        w_fwd2_hit = r_stg_valid && (r_stg.rd != '0) && (rs2 == r_stg.rd);
        fwd1_hit   = w_fwd1_hit;
        fwd2_hit   = w_fwd2_hit;
        fwd1_data  = w_fwd1_hit ? r_stg.data : '0;
        fwd2_data  = w_fwd2_hit ? r_stg.data : '0;
    end

endmodule
